// File: rtl/axil_arbiter_wr.sv
// Write-path arbiter for AXI-Lite masters: one grant held from AW&W request until the B handshake.
// Define AXIL_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module axil_arbiter_wr #(
    parameter int NUMBER_MASTER = 2,
    localparam int ID_WIDTH = (NUMBER_MASTER > 2) ? $clog2(NUMBER_MASTER) : 1
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUMBER_MASTER-1:0] req_awvalid,
    input  logic [NUMBER_MASTER-1:0] req_wvalid,
    input  logic                     bvalid,
    input  logic                     bready,
    output logic [NUMBER_MASTER-1:0] grant,
    output logic [ID_WIDTH-1:0]      grant_id,
    output logic                     busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                 state;
    logic [NUMBER_MASTER-1:0] req;
    logic                   found;
    logic [ID_WIDTH-1:0]    win_id;

    // A master is eligible only once both its address and data are offered.
    assign req = req_awvalid & req_wvalid;

`ifdef AXIL_ARB_ROUND_ROBIN_EN
    logic [ID_WIDTH-1:0] ptr;

    // Scan from the lowest to the highest priority so the last hit is the winner;
    // position k = 0 (the pointer itself) is therefore visited last.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        found  = 1'b0;
        win_id = '0;
        for (int k = NUMBER_MASTER - 1; k >= 0; k--) begin
            logic [ID_WIDTH-1:0] idx;
            idx = ID_WIDTH'((int'(ptr) + k) % NUMBER_MASTER);
            if (req[idx]) begin
                found  = 1'b1;
                win_id = idx;
            end
        end
    end
`else
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        for (int i = NUMBER_MASTER - 1; i >= 0; i--) begin
            if (req[i]) begin
                found  = 1'b1;
                win_id = ID_WIDTH'(i);
            end
        end
    end
`endif

    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!aresetn) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
            ptr      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= GRANT;
                        grant    <= NUMBER_MASTER'(1) << win_id;
                        grant_id <= win_id;
                        busy     <= 1'b1;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
                        ptr      <= (win_id == ID_WIDTH'(NUMBER_MASTER - 1)) ? '0 : win_id + 1'b1;
`endif
                    end
                end
                GRANT: begin
                    // Only the completed B handshake ends the grant; req is ignored here.
                    if (bvalid && bready) begin
                        state    <= IDLE;
                        grant    <= '0;
                        grant_id <= '0;
                        busy     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_arbiter_wr.sv
// Directed bench for axil_arbiter_wr with four masters; expectations follow the compiled policy.
module tb_axil_arbiter_wr;

    localparam int N = 4;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [N-1:0] req_awvalid;
    logic [N-1:0] req_wvalid;
    logic         bvalid;
    logic         bready;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;

    axil_arbiter_wr #(.NUMBER_MASTER(N)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .req_awvalid (req_awvalid),
        .req_wvalid  (req_wvalid),
        .bvalid      (bvalid),
        .bready      (bready),
        .grant       (grant),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0] aw;
        logic [3:0] w;
        logic       bv;
        logic       br;
        logic [3:0] g;
        logic [1:0] id;
        logic       bsy;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] g, input logic [1:0] id,
                             input logic bsy);
        check({name, ".grant"}, 32'(grant), 32'(g));
        check({name, ".grant_id"}, 32'(grant_id), 32'(id));
        check({name, ".busy"}, 32'(busy), 32'(bsy));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic [3:0] aw, input logic [3:0] w, input logic bv, input logic br);
        req_awvalid = aw;
        req_wvalid  = w;
        bvalid      = bv;
        bready      = br;
    endtask

    task automatic do_reset();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
    endtask

    // Hold req over n transactions, each released by a one-cycle B handshake.
    task automatic contend(input string name, input logic [3:0] r, input int n);
        int exp_id;
        drive(r, r, 1'b0, 1'b0);
        for (int t = 0; t < n; t++) begin
            step();
            if (r == 4'b1010) exp_id = (RR && (t % 2 == 1)) ? 3 : 1;
            else              exp_id = RR ? (t % 4) : 0;
            check_out($sformatf("%s_t%0d", name, t), 4'(1 << exp_id), 2'(exp_id), 1'b1);
            bvalid = 1'b1;
            bready = 1'b1;
            step();
            check_out($sformatf("%s_rel%0d", name, t), 4'b0000, 2'd0, 1'b0);
            bvalid = 1'b0;
            bready = 1'b0;
        end
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        // Policy-independent single-request vectors: one edge per record.
        vecs[0] = '{4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1};
        vecs[1] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1};
        vecs[2] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1};
        vecs[3] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1};
        vecs[4] = '{4'b0010, 4'b0010, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[5] = '{4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[6] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[7] = '{4'b1000, 4'b0100, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
        vecs[8] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0};

        drive(4'b1111, 4'b1111, 1'b0, 1'b0);
        aresetn = 1'b0;
        step();
        step();
        check_out("reset", 4'b0000, 2'd0, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        aresetn = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].aw, vecs[i].w, vecs[i].bv, vecs[i].br);
            step();
            check_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].id, vecs[i].bsy);
        end

        // Partial request: address without data is never granted.
        do_reset();
        drive(4'b0001, 4'b0000, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("partial_c%0d.grant", c), 32'(grant), 32'd0);
        end
        req_wvalid = 4'b0001;
        step();
        check_out("partial_done", 4'b0001, 2'd0, 1'b1);

        // B stall: bvalid without bready while req keeps moving.
        bvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req_awvalid = 4'(c * 5 + 2);
            req_wvalid  = 4'(c * 3 + 6);
            step();
            check_out($sformatf("stall_c%0d", c), 4'b0001, 2'd0, 1'b1);
        end
        drive(4'b0000, 4'b0000, 1'b1, 1'b1);
        step();
        check_out("stall_release", 4'b0000, 2'd0, 1'b0);

        do_reset();
        contend("c1010", 4'b1010, 3);
        do_reset();
        contend("c1111", 4'b1111, 5);

        // Reset mid-grant of master 3, then a fresh 1001 request goes to master 0.
        do_reset();
        drive(4'b1000, 4'b1000, 1'b0, 1'b0);
        step();
        check_out("pre_abort", 4'b1000, 2'd3, 1'b1);
        drive(4'b1001, 4'b1001, 1'b0, 1'b0);
        aresetn = 1'b0;
        step();
        check_out("abort", 4'b0000, 2'd0, 1'b0);
        aresetn = 1'b1;
        step();
        check_out("post_abort", 4'b0001, 2'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
